result_serializer: RTL and testbench

- Opposite end of the serial-to-parallel input shift_register that feeds the compressor.
- Accepts one parallel compressor result word (dst0..dst19 concatenated, dst0 = bit 0) per valid/ready handshake.
- Shifts the word out on a single pin, LSB first, with framing strobes and an optional even-parity bit.
- Contains a one-entry holding buffer, so back-to-back frames stream with zero idle cycles between them.

---
 rtl/result_ser_pkg.sv | 18 +
 rtl/result_serializer_if.sv | 27 ++
 rtl/ser_hold_buf.sv | 39 +++
 rtl/result_serializer.sv | 122 ++++++++++++
 tb/tb_result_serializer.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/result_ser_pkg.sv
// Shared types and helpers for the result serializer.
// State encoding, default word width and the parity function.
package result_ser_pkg;

   typedef enum logic [1:0] {
      IDLE,
      DATA,
      PAR
   } state_e;

   localparam int unsigned DEFAULT_WIDTH = 20;

   // Narrower words are zero-extended by the caller, which leaves the parity unchanged.
   function automatic logic even_parity(input logic [63:0] word);
      return ^word;
   endfunction

endpackage

// File: rtl/result_serializer_if.sv
// Parallel-in handshake and serial-out framing bundle of the result serializer.
interface result_serializer_if
   import result_ser_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             sout;
   logic             sout_valid;
   logic             sout_first;
   logic             sout_last;
   logic             busy;

   modport master (
      output in_valid, in_data,
      input  in_ready, sout, sout_valid, sout_first, sout_last, busy
   );

   modport slave (
      input  in_valid, in_data,
      output in_ready, sout, sout_valid, sout_first, sout_last, busy
   );

endinterface

// File: rtl/ser_hold_buf.sv
// Single-entry holding buffer between the producer and the shifter.
// A held word always has priority over a new input when the shifter frees up.
module ser_hold_buf #(
   parameter int unsigned WIDTH = 20
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_valid,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_free,
   output logic             o_ready,
   output logic             o_hold_valid,
   output logic             o_load,
   output logic [WIDTH-1:0] o_load_data
);

   logic             r_hold_valid;
   logic [WIDTH-1:0] r_hold;
   logic             w_accept;

   assign w_accept     = i_valid & ~r_hold_valid;
   assign o_ready      = ~r_hold_valid;
   assign o_hold_valid = r_hold_valid;
   assign o_load       = i_free & (r_hold_valid | w_accept);
   assign o_load_data  = r_hold_valid ? r_hold : i_data;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hold_valid <= 1'b0;
         r_hold       <= '0;
      end else if (r_hold_valid && i_free) begin
         r_hold_valid <= 1'b0;
      end else if (w_accept && !i_free) begin
         r_hold_valid <= 1'b1;
         r_hold       <= i_data;
      end
   end

endmodule

// File: rtl/result_serializer.sv
// Parallel-to-serial framer for compressor result words: LSB first, optional even parity,
// with registered first/last strobes and gap-free back-to-back frames.
module result_serializer
   import result_ser_pkg::*;
#(
   parameter int unsigned WIDTH     = DEFAULT_WIDTH,
   parameter bit          PARITY_EN = 1'b1,
   parameter int unsigned CNT_W     = $clog2(WIDTH + 1)
) (
   input logic                 clk,
   input logic                 rst_n,
   result_serializer_if.slave  bus
);

   state_e             r_state, w_state_d;
   logic [CNT_W-1:0]   r_cnt, w_cnt_d;
   logic [WIDTH-1:0]   r_shift, w_shift_d;
   logic               r_par, w_par_d;
   logic               r_sout, w_sout_d;
   logic               r_valid, w_valid_d;
   logic               r_first, w_first_d;
   logic               r_last, w_last_d;

   logic               w_eof;
   logic               w_free;
   logic               w_ready;
   logic               w_hold_valid;
   logic               w_load;
   logic [WIDTH-1:0]   w_load_data;

   // The shifter can take a new word at this edge when idle or emitting its final bit.
   assign w_eof  = ((r_state == DATA) && (r_cnt == CNT_W'(WIDTH - 1)) && !PARITY_EN) ||
                   (r_state == PAR);
   assign w_free = (r_state == IDLE) || w_eof;

   ser_hold_buf #(
      .WIDTH(WIDTH)
   ) u_hold (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_valid      (bus.in_valid),
      .i_data       (bus.in_data),
      .i_free       (w_free),
      .o_ready      (w_ready),
      .o_hold_valid (w_hold_valid),
      .o_load       (w_load),
      .o_load_data  (w_load_data)
   );

   always_comb begin
      w_state_d = r_state;
      w_cnt_d   = r_cnt;
      w_shift_d = r_shift;
      w_par_d   = r_par;
      w_sout_d  = 1'b0;
      w_valid_d = 1'b0;
      w_first_d = 1'b0;
      w_last_d  = 1'b0;

      case (r_state)
         DATA: begin
            if (r_cnt != CNT_W'(WIDTH - 1)) begin
               w_cnt_d   = r_cnt + CNT_W'(1);
               w_shift_d = r_shift >> 1;
               w_sout_d  = r_shift[1];
               w_valid_d = 1'b1;
               w_last_d  = !PARITY_EN && (r_cnt == CNT_W'(WIDTH - 2));
            end else if (PARITY_EN) begin
               w_state_d = PAR;
               w_sout_d  = r_par;
               w_valid_d = 1'b1;
               w_last_d  = 1'b1;
            end
         end
         default: ;
      endcase

      if (w_free) begin
         if (w_load) begin
            w_state_d = DATA;
            w_cnt_d   = '0;
            w_shift_d = w_load_data;
            w_par_d   = even_parity(64'(w_load_data));
            w_sout_d  = w_load_data[0];
            w_valid_d = 1'b1;
            w_first_d = 1'b1;
         end else begin
            w_state_d = IDLE;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_shift <= '0;
         r_par   <= 1'b0;
         r_sout  <= 1'b0;
         r_valid <= 1'b0;
         r_first <= 1'b0;
         r_last  <= 1'b0;
      end else begin
         r_state <= w_state_d;
         r_cnt   <= w_cnt_d;
         r_shift <= w_shift_d;
         r_par   <= w_par_d;
         r_sout  <= w_sout_d;
         r_valid <= w_valid_d;
         r_first <= w_first_d;
         r_last  <= w_last_d;
      end
   end

   assign bus.in_ready   = w_ready;
   assign bus.sout       = r_sout;
   assign bus.sout_valid = r_valid;
   assign bus.sout_first = r_first;
   assign bus.sout_last  = r_last;
   assign bus.busy       = (r_state != IDLE) || w_hold_valid;

endmodule

// File: tb/tb_result_serializer.sv
// Bench for result_serializer: two instances (20-bit with parity, 4-bit without) checked
// every cycle against a frame-schedule model, plus directed scenarios and random traffic.
module tb_result_serializer;

   localparam int W0   = 20;
   localparam int W1   = 4;
   localparam int MAXC = 2048;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   result_serializer_if #(.WIDTH(W0)) bus0 ();
   result_serializer_if #(.WIDTH(W1)) bus1 ();

   result_serializer #(.WIDTH(W0), .PARITY_EN(1'b1)) dut0 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus0)
   );

   result_serializer #(.WIDTH(W1), .PARITY_EN(1'b0)) dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus1)
   );

   // Expected serial timeline per instance, indexed by cycle number.
   logic        ev [2][MAXC];
   logic        eb [2][MAXC];
   logic        ef [2][MAXC];
   logic        el [2][MAXC];
   int          fend  [2];
   int          acc_c [2];
   int          acc_s [2];
   logic        accepted [2];
   logic [63:0] cap    [2];
   int          capn   [2];
   int          run    [2];
   int          maxrun [2];
   int          cyc;
   int          tests;
   int          fails;
   int          xs;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic clr_model(input int from);
      for (int d = 0; d < 2; d++) begin
         for (int c = from; c < MAXC; c++) begin
            ev[d][c] = 1'b0;
            eb[d][c] = 1'b0;
            ef[d][c] = 1'b0;
            el[d][c] = 1'b0;
         end
         fend[d]  = -10;
         acc_c[d] = -10;
         acc_s[d] = -10;
      end
   endtask

   // Ready unless an earlier accepted word is still waiting for its frame to begin.
   function automatic logic ready_m(input int d);
      return !((acc_c[d] < cyc) && (acc_s[d] > cyc));
   endfunction

   task automatic sched(input int d, input logic [63:0] w);
      int   wd, len, st;
      logic p;
      wd  = (d == 0) ? W0 : W1;
      len = (d == 0) ? W0 + 1 : W1;
      st  = (cyc + 1 > fend[d] + 1) ? cyc + 1 : fend[d] + 1;
      p   = 1'b0;
      for (int i = 0; i < wd; i++) begin
         ev[d][st+i] = 1'b1;
         eb[d][st+i] = w[i];
         p           = p ^ w[i];
      end
      if (d == 0) begin
         ev[d][st+wd] = 1'b1;
         eb[d][st+wd] = p;
      end
      ef[d][st]       = 1'b1;
      el[d][st+len-1] = 1'b1;
      fend[d]  = st + len - 1;
      acc_c[d] = cyc;
      acc_s[d] = st;
   endtask

   task automatic cap_clr();
      for (int d = 0; d < 2; d++) begin
         cap[d]    = '0;
         capn[d]   = 0;
         run[d]    = 0;
         maxrun[d] = 0;
      end
   endtask

   task automatic tick();
      logic o_v, o_s, o_f, o_l, o_b, o_r, iv, rm;
      @(negedge clk);
      if (cyc >= MAXC - 100) begin
         $display("FAIL cycle_budget cyc=%0d limit=%0d", cyc, MAXC - 100);
         $fatal(1, "cycle budget exhausted");
      end
      for (int d = 0; d < 2; d++) begin
         if (d == 0) begin
            o_v = bus0.sout_valid; o_s = bus0.sout; o_f = bus0.sout_first;
            o_l = bus0.sout_last;  o_b = bus0.busy; o_r = bus0.in_ready; iv = bus0.in_valid;
         end else begin
            o_v = bus1.sout_valid; o_s = bus1.sout; o_f = bus1.sout_first;
            o_l = bus1.sout_last;  o_b = bus1.busy; o_r = bus1.in_ready; iv = bus1.in_valid;
         end
         rm = ready_m(d);
         chk($sformatf("d%0d_sout_valid", d), 64'(o_v), 64'(ev[d][cyc]));
         chk($sformatf("d%0d_sout_first", d), 64'(o_f), 64'(ef[d][cyc]));
         chk($sformatf("d%0d_sout_last", d), 64'(o_l), 64'(el[d][cyc]));
         chk($sformatf("d%0d_busy", d), 64'(o_b), 64'(ev[d][cyc]));
         chk($sformatf("d%0d_in_ready", d), 64'(o_r), 64'(rm));
         if (ev[d][cyc]) chk($sformatf("d%0d_sout", d), 64'(o_s), 64'(eb[d][cyc]));
         if (o_v) begin
            if (capn[d] < 64) cap[d][capn[d]] = o_s;
            capn[d]++;
            run[d]++;
         end else begin
            run[d] = 0;
         end
         if (run[d] > maxrun[d]) maxrun[d] = run[d];
         accepted[d] = iv && rm && rst_n;
         if (accepted[d]) sched(d, (d == 0) ? 64'(bus0.in_data) : 64'(bus1.in_data));
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic offer(input int d, input logic [63:0] w);
      int   k;
      logic got;
      k   = 0;
      got = 1'b0;
      if (d == 0) begin bus0.in_valid = 1'b1; bus0.in_data = W0'(w); end
      else        begin bus1.in_valid = 1'b1; bus1.in_data = W1'(w); end
      while (!got && k < 100) begin
         tick();
         got = accepted[d];
         k++;
      end
      if (d == 0) bus0.in_valid = 1'b0;
      else        bus1.in_valid = 1'b0;
      chk($sformatf("d%0d_offer_accepted", d), 64'(got), 64'd1);
   endtask

   initial begin
      tests = 0;
      fails = 0;
      rst_n = 1'b0;
      bus0.in_valid = 1'b0; bus0.in_data = '0;
      bus1.in_valid = 1'b0; bus1.in_data = '0;
      clr_model(0);
      cap_clr();
      @(posedge clk);
      #1;
      cyc = 0;
      idle(3);
      rst_n = 1'b1;
      chk("rdy_after_rst", 64'(bus0.in_ready), 64'd1);

      // Single word: bit0 set, parity 1, 21-cycle frame.
      offer(0, 64'h00001);
      idle(25);
      chk("single_bits", cap[0], 64'h100001);
      chk("single_len", 64'(capn[0]), 64'd21);

      cap_clr();
      offer(0, 64'hFFFFF);
      idle(25);
      chk("ones_bits", cap[0], 64'h0FFFFF);
      chk("ones_len", 64'(capn[0]), 64'd21);

      // Back-to-back pair streams as one 42-cycle burst.
      cap_clr();
      offer(0, 64'hAAAAA);
      offer(0, 64'h55555);
      idle(50);
      chk("b2b_bits", cap[0], (64'h55555 << 21) | 64'hAAAAA);
      chk("b2b_run", 64'(maxrun[0]), 64'd42);

      // Third word stalls while the hold register is full, then follows gap-free.
      cap_clr();
      offer(0, 64'h12345);
      offer(0, 64'h6789A);
      offer(0, 64'hBCDEF);
      idle(70);
      chk("three_run", 64'(maxrun[0]), 64'd63);

      // Reset on bit 10 with a word held.
      offer(0, 64'hC3A5F);
      xs = acc_s[0];
      offer(0, 64'h0F0F0);
      while (cyc < xs + 10) tick();
      rst_n = 1'b0;
      clr_model(cyc);
      #1;
      chk("rst_sout_valid", 64'(bus0.sout_valid), 64'd0);
      chk("rst_busy", 64'(bus0.busy), 64'd0);
      chk("rst_sout", 64'(bus0.sout), 64'd0);
      cap_clr();
      idle(2);
      rst_n = 1'b1;
      idle(40);
      chk("rst_no_residual", 64'(capn[0]), 64'd0);

      // 4-bit instance without parity.
      cap_clr();
      offer(1, 64'hB);
      idle(10);
      chk("w4_bits", cap[1], 64'hB);
      chk("w4_len", 64'(capn[1]), 64'd4);

      for (int n = 0; n < 500; n++) begin
         bus0.in_valid = ($urandom_range(0, 3) != 0);
         bus0.in_data  = W0'($urandom);
         bus1.in_valid = ($urandom_range(0, 2) != 0);
         bus1.in_data  = W1'($urandom);
         tick();
      end
      bus0.in_valid = 1'b0;
      bus1.in_valid = 1'b0;
      idle(60);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
